// File: rtl/cba_multiword_seq.sv
// rtl/cba_multiword_seq.sv - multi-word sequencer around a carry-bypass adder, one word slice per cycle

module carry_bypass_adder #(
    parameter int INPUT_LEN = 8
) (
    input  logic [INPUT_LEN-1:0] a,
    input  logic [INPUT_LEN-1:0] b,
    input  logic                 c,
    output logic [INPUT_LEN-1:0] sum,
    output logic                 cout
);
    localparam int BLK = 4;

    logic [INPUT_LEN-1:0] p;
    logic [INPUT_LEN-1:0] g;
    logic                 cy;
    logic                 blk_cin;
    logic                 blk_p;

    // Ripple inside each 4-bit block; a fully propagating block passes its carry-in straight through.
    always_comb begin
        p       = a ^ b;
        g       = a & b;
        sum     = '0;
        cy      = c;
        blk_cin = c;
        blk_p   = 1'b1;
        for (int i = 0; i < INPUT_LEN; i++) begin
            if ((i % BLK) == 0) begin
                blk_cin = cy;
                blk_p   = 1'b1;
            end
            sum[i] = p[i] ^ cy;
            cy     = g[i] | (p[i] & cy);
            blk_p  = blk_p & p[i];
            if (((i % BLK) == BLK - 1) || (i == INPUT_LEN - 1)) begin
                cy = blk_p ? blk_cin : cy;
            end
        end
        cout = cy;
    end
endmodule

module cba_multiword_seq #(
    parameter int WORD_LEN = 8,
    parameter int NWORDS   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NWORDS*WORD_LEN-1:0] in_a,
    input  logic [NWORDS*WORD_LEN-1:0] in_b,
    input  logic                       in_cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NWORDS*WORD_LEN-1:0] out_sum,
    output logic                       out_cout,
    output logic                       busy
);
    localparam int W     = NWORDS * WORD_LEN;
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       res_q, res_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [WORD_LEN-1:0] slice_a;
    logic [WORD_LEN-1:0] slice_b;
    logic [WORD_LEN-1:0] slice_sum;
    logic                slice_cout;

    assign slice_a = a_q[int'(idx_q) * WORD_LEN +: WORD_LEN];
    assign slice_b = b_q[int'(idx_q) * WORD_LEN +: WORD_LEN];

    carry_bypass_adder #(.INPUT_LEN(WORD_LEN)) u_adder (slice_a, slice_b, carry_q, slice_sum, slice_cout);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[int'(idx_q) * WORD_LEN +: WORD_LEN] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == IDX_W'(NWORDS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags are registered from the next state so they switch together with it.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = res_q;
    assign out_cout  = carry_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_cba_multiword_seq.sv
// tb/tb_cba_multiword_seq.sv - self-checking bench for cba_multiword_seq (NWORDS=4 and NWORDS=1)

module tb_cba_multiword_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_cin, out_ready;
    logic [31:0] in_a, in_b;
    logic        in_ready, out_valid, out_cout, busy;
    logic [31:0] out_sum;

    logic        rst1_n;
    logic        u1_in_valid, u1_in_cin, u1_out_ready;
    logic [7:0]  u1_in_a, u1_in_b;
    logic        u1_in_ready, u1_out_valid, u1_out_cout, u1_busy;
    logic [7:0]  u1_out_sum;

    int checks = 0;
    int failures = 0;

    logic [32:0] exp_q[$];
    logic [8:0]  exp1_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        int          stall;
        logic [32:0] exp;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    cba_multiword_seq #(.WORD_LEN(8), .NWORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    cba_multiword_seq #(.WORD_LEN(8), .NWORDS(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
        .in_a(u1_in_a), .in_b(u1_in_b), .in_cin(u1_in_cin), .out_valid(u1_out_valid),
        .out_ready(u1_out_ready), .out_sum(u1_out_sum), .out_cout(u1_out_cout), .busy(u1_busy)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input int stall, input logic [32:0] exp);
        int guard;
        int lat;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        out_ready = (stall == 0);
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk("in_ready_wait", in_ready, 1);
        tick();
        exp_q.push_back(exp);
        in_valid = 1'b0;
        chk("busy_after_capture", {in_ready, busy}, 2'b01);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency4", lat, 4);
        for (int s = 0; s < stall; s++) begin
            chk("hold_valid_ready_busy", {out_valid, in_ready, busy}, 3'b101);
            chk("hold_result", {out_cout, out_sum}, exp_q.size() > 0 ? exp_q[0] : 33'h0);
            tick();
        end
        out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            chk("result4", {out_cout, out_sum}, exp_q.pop_front());
        end
        tick();
        chk("post_handshake", {out_valid, in_ready, busy}, 3'b010);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 0, 33'h1_00000000};
        vecs[1] = '{32'h12345678, 32'h11111111, 1'b0, 0, 33'h0_23456789};
        vecs[2] = '{32'h80000000, 32'h80000000, 1'b0, 5, 33'h1_00000000};
        vecs[3] = '{32'h00000000, 32'h00000000, 1'b0, 1, 33'h0_00000000};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 2, 33'h1_FFFFFFFF};
        vecs[5] = '{32'h0000FFFF, 32'h00000001, 1'b0, 0, 33'h0_00010000};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        rst1_n = 1'b0; u1_in_valid = 1'b0; u1_in_a = '0; u1_in_b = '0; u1_in_cin = 1'b0; u1_out_ready = 1'b0;
        repeat (3) tick();
        chk("reset_flags", {in_ready, out_valid, busy, out_cout}, 4'b1000);
        chk("reset_sum", out_sum, 0);
        rst_n = 1'b1;
        rst1_n = 1'b1;
        tick();
        chk("after_release", {in_ready, out_valid, busy}, 3'b100);

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    do_op4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall, vecs[i].exp);
                end

                // in_valid held high with new operands while RUN/DONE must not capture
                in_valid = 1'b1; in_a = 32'h10; in_b = 32'h20; in_cin = 1'b0; out_ready = 1'b1;
                tick();
                exp_q.push_back(33'h30);
                in_a = 32'h1; in_b = 32'h1;
                for (int k = 0; k < 4; k++) begin
                    chk("no_capture_run", {in_ready, busy}, 2'b01);
                    tick();
                end
                chk("first_op_valid", out_valid, 1);
                chk("first_op_result", {out_cout, out_sum}, exp_q.size() > 0 ? exp_q.pop_front() : 33'h1_FFFFFFFF);
                tick();
                chk("idle_with_valid", {in_ready, out_valid}, 2'b10);
                tick();
                exp_q.push_back(33'h2);
                in_valid = 1'b0;
                repeat (4) tick();
                chk("second_op_valid", out_valid, 1);
                chk("second_op_result", {out_cout, out_sum}, exp_q.size() > 0 ? exp_q.pop_front() : 33'h1_FFFFFFFF);
                tick();
                out_ready = 1'b0;

                // reset in the middle of RUN at idx 2
                in_valid = 1'b1; in_a = 32'hFFFFFFFF; in_b = 32'h1; in_cin = 1'b0;
                tick();
                exp_q.push_back(33'h1_00000000);
                in_valid = 1'b0;
                tick();
                tick();
                rst_n = 1'b0;
                #1;
                exp_q.delete();
                chk("async_rst_flags", {in_ready, out_valid, busy, out_cout}, 4'b1000);
                chk("async_rst_sum", out_sum, 0);
                repeat (2) begin
                    tick();
                    chk("rst_no_valid", out_valid, 0);
                end
                rst_n = 1'b1;
                repeat (6) begin
                    tick();
                    chk("post_rst_no_valid", {out_valid, in_ready}, 2'b01);
                end
                do_op4(32'hFFFFFFFF, 32'h1, 1'b0, 1, 33'h1_00000000);

                for (int r = 0; r < 200; r++) begin
                    logic [31:0] ra, rb;
                    logic        rc;
                    ra = $urandom;
                    rb = $urandom;
                    rc = 1'($urandom_range(0, 1));
                    do_op4(ra, rb, rc, $urandom_range(0, 3), {1'b0, ra} + {1'b0, rb} + {32'd0, rc});
                end
                chk("sb4_drained", exp_q.size(), 0);
            end
            begin
                for (int r = 0; r < 60; r++) begin
                    logic [7:0] ra, rb;
                    logic       rc;
                    int         stall;
                    int         lat;
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    stall = $urandom_range(0, 3);
                    u1_in_valid = 1'b1; u1_in_a = ra; u1_in_b = rb; u1_in_cin = rc;
                    u1_out_ready = (stall == 0);
                    chk("n1_in_ready", u1_in_ready, 1);
                    tick();
                    exp1_q.push_back({1'b0, ra} + {1'b0, rb} + {8'd0, rc});
                    u1_in_valid = 1'b0;
                    lat = 0;
                    while (!u1_out_valid && lat < 20) begin
                        tick();
                        lat++;
                    end
                    chk("n1_latency", lat, 1);
                    for (int s = 0; s < stall; s++) begin
                        chk("n1_hold", {u1_out_valid, u1_in_ready, u1_busy}, 3'b101);
                        tick();
                    end
                    u1_out_ready = 1'b1;
                    if (exp1_q.size() == 0) chk("n1_sb_empty", 0, 1);
                    else chk("n1_result", {u1_out_cout, u1_out_sum}, exp1_q.pop_front());
                    tick();
                    chk("n1_post", {u1_out_valid, u1_in_ready}, 2'b01);
                    u1_out_ready = 1'b0;
                end
                chk("sb1_drained", exp1_q.size(), 0);
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
